rom_download_writer: RTL and testbench

Writer end of the core's dual-port ROM/RAM: takes the HPS ioctl byte stream during a ROM download and turns it into word writes on one port of a `dpram` instance. Bytes are packed little-endian into `DATA_WIDTH` words, range-checked, and buffered in a 2-entry FIFO. The FIFO absorbs cycles where the game logic owns the port (`ram_busy`), with `ioctl_wait` back-pressure. Sits between the HPS I/O block and the `dpram` port B of each ROM region.

---
 rtl/rom_download_writer.sv | 187 ++++++++++++++++++
 tb/tb_rom_download_writer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_writer.sv
// Packs the HPS ioctl byte stream into DATA_WIDTH words and writes them to one dpram port through a 2-entry FIFO.
// Optional byte checksum of the download is built when ROM_DOWNLOAD_CHECKSUM_EN is defined.
module rom_download_writer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int INDEX         = 0,
  parameter int BASE          = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ioctl_download,
  input  logic [7:0]               ioctl_index,
  input  logic                     ioctl_wr,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  output logic                     ioctl_wait,
  input  logic                     ram_busy,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_data,
  output logic                     ram_enable,
  output logic                     ram_wren,
  output logic                     loading,
  output logic                     done,
  output logic [15:0]              checksum
);

  localparam int B      = DATA_WIDTH / 8;
  localparam int SHIFT  = (B > 1) ? $clog2(B) : 0;
  localparam int LANE_W = (B > 1) ? $clog2(B) : 1;
  localparam logic [24:0] BASE_L  = 25'(BASE);
  localparam logic [7:0]  INDEX_L = 8'(INDEX);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t                   state_reg;
  logic                     dl_prev_reg;
  logic [DATA_WIDTH-1:0]    pack_reg;
  logic [ADDRESS_WIDTH-1:0] pack_addr_reg;
  logic                     pending_reg;
  logic [ADDRESS_WIDTH-1:0] fifo_addr_reg [2];
  logic [DATA_WIDTH-1:0]    fifo_data_reg [2];
  logic                     wr_ptr_reg;
  logic                     rd_ptr_reg;
  logic [1:0]               count_reg;

  logic [24:0]              off;
  logic [24:0]              word_full;
  logic [ADDRESS_WIDTH-1:0] word;
  logic [LANE_W-1:0]        lane;
  logic                     in_range;
  logic                     accept;
  logic                     take;
  logic                     lane_last;
  logic                     load_push;
  logic                     flush_push;
  logic                     push;
  logic                     pop;
  logic [ADDRESS_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0]    push_data;
  logic [DATA_WIDTH-1:0]    pack_merge;

  assign off       = ioctl_addr - BASE_L;
  assign word_full = off >> SHIFT;
  assign word      = ADDRESS_WIDTH'(word_full);
  assign in_range  = (ioctl_addr >= BASE_L) && ((word_full >> ADDRESS_WIDTH) == 25'd0);

  generate
    if (B > 1) begin : g_lane
      assign lane = off[LANE_W-1:0];
    end else begin : g_lane_single
      assign lane = '0;
    end
  endgenerate

  // Current pack word with the incoming byte dropped into its lane.
  generate
    for (genvar gi = 0; gi < B; gi++) begin : g_merge
      assign pack_merge[gi*8 +: 8] = (lane == LANE_W'(gi)) ? ioctl_dout : pack_reg[gi*8 +: 8];
    end
  endgenerate

  assign ioctl_wait = (count_reg == 2'd2);
  assign accept     = (state_reg == LOAD) && ioctl_wr && !ioctl_wait;
  assign take       = accept && in_range;
  assign lane_last  = (lane == LANE_W'(B - 1));
  assign load_push  = take && lane_last;
  assign flush_push = (state_reg == FLUSH) && pending_reg && (count_reg != 2'd2);
  assign push       = load_push || flush_push;
  assign push_addr  = load_push ? word : pack_addr_reg;
  assign push_data  = load_push ? pack_merge : pack_reg;
  assign pop        = (count_reg != 2'd0) && !ram_busy;

  assign ram_enable  = pop;
  assign ram_wren    = pop;
  assign ram_address = fifo_addr_reg[rd_ptr_reg];
  assign ram_data    = fifo_data_reg[rd_ptr_reg];
  assign loading     = (state_reg == LOAD) || (state_reg == FLUSH);
  assign done        = (state_reg == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      dl_prev_reg   <= 1'b0;
      pack_reg      <= '0;
      pack_addr_reg <= '0;
      pending_reg   <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_addr_reg[i] <= '0;
        fifo_data_reg[i] <= '0;
      end
    end else begin
      dl_prev_reg <= ioctl_download;

      if (push) begin
        fifo_addr_reg[wr_ptr_reg] <= push_addr;
        fifo_data_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg                <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase

      case (state_reg)
        IDLE: begin
          if (ioctl_download && !dl_prev_reg && (ioctl_index == INDEX_L)) begin
            state_reg   <= LOAD;
            pack_reg    <= '0;
            pending_reg <= 1'b0;
          end
        end
        LOAD: begin
          if (take) begin
            if (lane_last) begin
              pack_reg    <= '0;
              pending_reg <= 1'b0;
            end else begin
              pack_reg      <= pack_merge;
              pack_addr_reg <= word;
              pending_reg   <= 1'b1;
            end
          end
          if (!ioctl_download) begin
            state_reg <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_push) begin
            pack_reg    <= '0;
            pending_reg <= 1'b0;
          end else if (!pending_reg && (count_reg == 2'd0)) begin
            state_reg <= DONE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef ROM_DOWNLOAD_CHECKSUM_EN
  logic [15:0] checksum_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      checksum_reg <= 16'd0;
    end else if ((state_reg == IDLE) && ioctl_download && !dl_prev_reg && (ioctl_index == INDEX_L)) begin
      checksum_reg <= 16'd0;
    end else if (take) begin
      checksum_reg <= checksum_reg + {8'd0, ioctl_dout};
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_rom_download_writer.sv
// Directed bench for rom_download_writer: 16-bit words, 16-word region at byte offset 0x100, index 3.
module tb_rom_download_writer;

  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int IDX  = 3;
  localparam int BASE = 32'h100;
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = 25'd0;
  logic [7:0]    ioctl_dout = 8'd0;
  logic          ioctl_wait;
  logic          ram_busy = 1'b0;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_enable;
  logic          ram_wren;
  logic          loading;
  logic          done;
  logic [15:0]   checksum;

  rom_download_writer #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .INDEX(IDX), .BASE(BASE)
  ) dut (
    .clock(clock), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .ram_busy(ram_busy),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_enable(ram_enable), .ram_wren(ram_wren),
    .loading(loading), .done(done), .checksum(checksum)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  logic [31:0] wq[$];
  int          done_cnt = 0;
  bit          loading_seen = 0;
  bit          wait_seen = 0;
  bit          busy_write = 0;

  always @(negedge clock) begin
    if (ram_wren) wq.push_back(32'({ram_address, ram_data}));
    if (done) done_cnt++;
    if (loading) loading_seen = 1;
    if (ioctl_wait) wait_seen = 1;
    if (ram_busy && ram_wren) busy_write = 1;
  end

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  dout;
    bit          exp_wr;
    logic [3:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = !ioctl_wait;
      tick();
      n++;
    end
    ioctl_wr = 1'b0;
    if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  // Drops ioctl_download and watches up to 30 cycles for the done pulse.
  task automatic finish_dl(output int first);
    first = -1;
    ioctl_download = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done && first < 0) first = i;
      tick();
    end
  endtask

  task automatic check_wq(input string name, input int i, input logic [31:0] exp);
    logic [31:0] act;
    act = (i < wq.size()) ? wq[i] : 32'hDEAD_BEEF;
    check(name, act, exp);
  endtask

  initial begin
    int first;

    vecs[0] = '{25'h0FF, 8'h77, 1'b0, 4'd0, 16'h0000};
    vecs[1] = '{25'h120, 8'h88, 1'b0, 4'd0, 16'h0000};
    vecs[2] = '{25'h100, 8'h11, 1'b0, 4'd0, 16'h0000};
    vecs[3] = '{25'h101, 8'h22, 1'b1, 4'd0, 16'h2211};
    vecs[4] = '{25'h102, 8'h33, 1'b0, 4'd0, 16'h0000};
    vecs[5] = '{25'h103, 8'h44, 1'b1, 4'd1, 16'h4433};

    // Reset state
    @(negedge clock);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_wren", 32'({ram_enable, ram_wren}), 32'd0);
    check("rst_addr_data", 32'({ram_address, ram_data}), 32'd0);
    check("rst_loading_done", 32'({loading, done}), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Table: out-of-range bytes, then two full words
    wq.delete();
    done_cnt = 0;
    start_dl(8'(IDX));
    @(negedge clock);
    check("t1_loading", 32'(loading), 32'd1);
    tick();
    for (int i = 0; i < 6; i++) begin
      send_byte(vecs[i].addr, vecs[i].dout);
      @(negedge clock);
      check($sformatf("t1_v%0d_wren", i), 32'(ram_wren), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr)
        check($sformatf("t1_v%0d_word", i), 32'({ram_address, ram_data}),
              32'({vecs[i].exp_addr, vecs[i].exp_data}));
      tick();
    end
    finish_dl(first);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_done_lat", 32'(first), 32'd2);
    check("t1_nwrites", 32'(wq.size()), 32'd2);
    check("t1_checksum", 32'(checksum), CS_EN ? 32'h00AA : 32'd0);
    check("t1_loading_end", 32'(loading), 32'd0);

    // Partial last word flushed on download fall
    wq.delete();
    done_cnt = 0;
    start_dl(8'(IDX));
    send_byte(25'h100, 8'hAA);
    send_byte(25'h101, 8'hBB);
    send_byte(25'h102, 8'hCC);
    finish_dl(first);
    check("t2_nwrites", 32'(wq.size()), 32'd2);
    check_wq("t2_w0", 0, 32'h0_BBAA);
    check_wq("t2_w1", 1, 32'h1_00CC);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_done_late", 32'(first >= 2), 32'd1);
    check("t2_checksum", 32'(checksum), CS_EN ? 32'h0231 : 32'd0);

    // Busy port fills the FIFO and back-pressures the HPS
    wq.delete();
    done_cnt = 0;
    wait_seen = 0;
    busy_write = 0;
    start_dl(8'(IDX));
    fork
      begin
        ram_busy = 1'b1;
        repeat (6) tick();
        ram_busy = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) send_byte(25'h100 + 25'(i), 8'(i + 1));
      end
    join
    finish_dl(first);
    check("t3_wait_seen", 32'(wait_seen), 32'd1);
    check("t3_busy_write", 32'(busy_write), 32'd0);
    check("t3_nwrites", 32'(wq.size()), 32'd4);
    check_wq("t3_w0", 0, 32'h0_0201);
    check_wq("t3_w1", 1, 32'h1_0403);
    check_wq("t3_w2", 2, 32'h2_0605);
    check_wq("t3_w3", 3, 32'h3_0807);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_checksum", 32'(checksum), CS_EN ? 32'h0024 : 32'd0);

    // Download for another index is ignored
    wq.delete();
    done_cnt = 0;
    loading_seen = 0;
    start_dl(8'd5);
    send_byte(25'h100, 8'h99);
    send_byte(25'h101, 8'h98);
    finish_dl(first);
    check("t4_loading", 32'(loading_seen), 32'd0);
    check("t4_nwrites", 32'(wq.size()), 32'd0);
    check("t4_done_cnt", 32'(done_cnt), 32'd0);
    check("t4_checksum_held", 32'(checksum), CS_EN ? 32'h0024 : 32'd0);

    // Reset mid-load with a word queued behind a busy port
    start_dl(8'(IDX));
    ram_busy = 1'b1;
    send_byte(25'h100, 8'h5A);
    send_byte(25'h101, 8'hA5);
    @(negedge clock);
    check("t5_queued", 32'({ram_wren, ram_address, ram_data}), 32'h0_A55A);
    check("t5_checksum_pre", 32'(checksum), CS_EN ? 32'h00FF : 32'd0);
    #2;
    reset = 1'b1;
    ram_busy = 1'b0;
    ioctl_download = 1'b0;
    wq.delete();
    #1;
    check("t5_rst_io", 32'({ioctl_wait, ram_enable, ram_wren, loading, done}), 32'd0);
    check("t5_rst_addr_data", 32'({ram_address, ram_data}), 32'd0);
    check("t5_rst_checksum", 32'(checksum), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    check("t5_no_write", 32'(wq.size()), 32'd0);
    done_cnt = 0;
    start_dl(8'(IDX));
    send_byte(25'h100, 8'h12);
    send_byte(25'h101, 8'h34);
    finish_dl(first);
    check("t5_nwrites", 32'(wq.size()), 32'd1);
    check_wq("t5_w0", 0, 32'h0_3412);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);
    check("t5_checksum", 32'(checksum), CS_EN ? 32'h0046 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
